// File: rtl/display_line_buffer.sv
// rtl/display_line_buffer.sv - one-line character buffer with write cursor, scroll/wrap, timed clear
// and a registered read port that overlays a blinking caret at the cursor.
module display_line_buffer #(
  parameter int DISPLAY_LENGTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CARET_CHAR = DATA_WIDTH'(8'h5F),
  parameter logic [DATA_WIDTH-1:0] BLANK_CHAR = DATA_WIDTH'(8'h20),
  parameter int SCROLL_MODE = 1,
  localparam int ADDR_WIDTH = $clog2(DISPLAY_LENGTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_read_enable,
  input  logic [ADDR_WIDTH-1:0] i_read_address,
  input  logic                  i_caret_strobe,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [ADDR_WIDTH-1:0] o_cursor,
  output logic                  o_line_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DISPLAY_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] cells [DISPLAY_LENGTH];
  logic [ADDR_WIDTH-1:0] cursor;
  logic                  full;
  logic [ADDR_WIDTH-1:0] clear_idx;

  logic is_printable;
  logic is_backspace;
  logic is_return;
  logic is_formfeed;

  assign is_printable = (i_data >= DATA_WIDTH'(8'h20)) && (i_data <= DATA_WIDTH'(8'h7E));
  assign is_backspace = (i_data == DATA_WIDTH'(8'h08));
  assign is_return    = (i_data == DATA_WIDTH'(8'h0D));
  assign is_formfeed  = (i_data == DATA_WIDTH'(8'h0C));

  assign o_ready     = (state == IDLE);
  assign o_cursor    = cursor;
  assign o_line_full = full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cursor      <= '0;
      full        <= 1'b0;
      clear_idx   <= '0;
      o_read_data <= '0;
      for (int k = 0; k < DISPLAY_LENGTH; k++) cells[k] <= BLANK_CHAR;
    end else begin
      // Read samples pre-write cells and cursor, so same-cycle writes are not visible.
      if (i_read_enable) begin
        if (int'(i_read_address) >= DISPLAY_LENGTH)
          o_read_data <= BLANK_CHAR;
        else if (i_read_address == cursor && !i_caret_strobe)
          o_read_data <= CARET_CHAR;
        else
          o_read_data <= cells[i_read_address];
      end

      case (state)
        IDLE: begin
          if (i_valid) begin
            if (is_printable) begin
              if (cursor != LAST) begin
                cells[cursor] <= i_data;
                cursor        <= cursor + ONE;
              end else if (!full) begin
                cells[LAST] <= i_data;
                full        <= 1'b1;
              end else if (SCROLL_MODE != 0) begin
                for (int k = 0; k < DISPLAY_LENGTH - 1; k++) cells[k] <= cells[k+1];
                cells[LAST] <= i_data;
              end else begin
                cells[0] <= i_data;
                cursor   <= ONE;
                full     <= 1'b0;
              end
            end else if (is_backspace) begin
              // A full line has its cursor parked on the last cell, which is the one to erase.
              if (full) begin
                cells[LAST] <= BLANK_CHAR;
                full        <= 1'b0;
              end else if (cursor != '0) begin
                cursor              <= cursor - ONE;
                cells[cursor - ONE] <= BLANK_CHAR;
              end
            end else if (is_return) begin
              cursor <= '0;
              full   <= 1'b0;
            end else if (is_formfeed) begin
              state     <= CLEAR;
              clear_idx <= '0;
            end
          end
        end

        CLEAR: begin
          cells[clear_idx] <= BLANK_CHAR;
          if (clear_idx == LAST) begin
            state     <= IDLE;
            cursor    <= '0;
            full      <= 1'b0;
            clear_idx <= '0;
          end else begin
            clear_idx <= clear_idx + ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_line_buffer.sv
// tb/tb_display_line_buffer.sv - bench for display_line_buffer, wrap (index 0) and scroll (index 1)
// instances driven in lockstep against a character-level line model.
module tb_display_line_buffer;

  localparam int L = 16;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       read_en;
  logic [3:0] addr;
  logic       strobe;

  logic [1:0] rdy;
  logic [1:0] full_o;
  logic [7:0] rdat [2];
  logic [3:0] cur_o [2];

  int total = 0;
  int bad = 0;

  logic [7:0] m_cells [2][L];
  int         m_cur [2];
  bit         m_full [2];
  int         m_clr [2];
  logic [7:0] m_rd [2];

  display_line_buffer #(.SCROLL_MODE(0)) dut_wrap (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_data(data), .o_ready(rdy[0]),
    .i_read_enable(read_en), .i_read_address(addr), .i_caret_strobe(strobe),
    .o_read_data(rdat[0]), .o_cursor(cur_o[0]), .o_line_full(full_o[0])
  );

  display_line_buffer #(.SCROLL_MODE(1)) dut_scroll (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_data(data), .o_ready(rdy[1]),
    .i_read_enable(read_en), .i_read_address(addr), .i_caret_strobe(strobe),
    .o_read_data(rdat[1]), .o_cursor(cur_o[1]), .o_line_full(full_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_char(input int m, input logic [7:0] c);
    logic [7:0] q[$];
    if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_cur[m] < L - 1) begin
        m_cells[m][m_cur[m]] = c;
        m_cur[m]++;
      end else if (!m_full[m]) begin
        m_cells[m][L-1] = c;
        m_full[m] = 1;
      end else if (m == 1) begin
        q = {};
        for (int k = 0; k < L; k++) q.push_back(m_cells[m][k]);
        void'(q.pop_front());
        q.push_back(c);
        for (int k = 0; k < L; k++) m_cells[m][k] = q[k];
      end else begin
        m_cells[m][0] = c;
        m_cur[m] = 1;
        m_full[m] = 0;
      end
    end else if (c == 8'h08) begin
      if (m_full[m]) begin
        m_cells[m][L-1] = 8'h20;
        m_full[m] = 0;
      end else if (m_cur[m] > 0) begin
        m_cur[m]--;
        m_cells[m][m_cur[m]] = 8'h20;
      end
    end else if (c == 8'h0D) begin
      m_cur[m] = 0;
      m_full[m] = 0;
    end else if (c == 8'h0C) begin
      m_clr[m] = L;
    end
  endtask

  // Advance the model by one clock with the current inputs, then let the DUT take the edge.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int k = 0; k < L; k++) m_cells[m][k] = 8'h20;
        m_cur[m] = 0; m_full[m] = 0; m_clr[m] = 0; m_rd[m] = 8'h00;
      end else begin
        if (read_en) begin
          if (int'(addr) >= L) m_rd[m] = 8'h20;
          else if (int'(addr) == m_cur[m] && !strobe) m_rd[m] = 8'h5F;
          else m_rd[m] = m_cells[m][addr];
        end
        if (m_clr[m] > 0) begin
          m_cells[m][L - m_clr[m]] = 8'h20;
          m_clr[m]--;
          if (m_clr[m] == 0) begin
            m_cur[m] = 0;
            m_full[m] = 0;
          end
        end else if (valid) begin
          model_char(m, data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    valid = 1'b1; data = c;
    tick();
    valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic s);
    read_en = 1'b1; addr = 4'(a); strobe = s;
    tick();
    read_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (rdat[m] !== 8'h00) begin bad++; $display("FAIL reset_rdata dut%0d got=%h exp=00", m, rdat[m]); end
    end
    for (int a = 0; a < L; a++) begin
      rd(a, 1'b1);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdat[m] !== 8'h20) begin bad++; $display("FAIL reset_cell dut%0d addr=%0d got=%h exp=20", m, a, rdat[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (cur_o[m] !== 4'd0 || full_o[m] !== 1'b0 || rdy[m] !== 1'b1) begin
        bad++; $display("FAIL reset_state dut%0d cursor=%0d full=%b ready=%b exp 0/0/1", m, cur_o[m], full_o[m], rdy[m]);
      end
    end
  endtask

  task automatic test_fill_scroll();
    for (int i = 0; i < L; i++) send(8'h41 + 8'(i));
    for (int m = 0; m < 2; m++) begin
      total++;
      if (cur_o[m] !== 4'd15 || full_o[m] !== 1'b1) begin
        bad++; $display("FAIL fill_state dut%0d cursor=%0d full=%b exp 15/1", m, cur_o[m], full_o[m]);
      end
    end
    send(8'h51);
    total++;
    if (cur_o[1] !== 4'd15 || full_o[1] !== 1'b1) begin
      bad++; $display("FAIL scroll_state cursor=%0d full=%b exp 15/1", cur_o[1], full_o[1]);
    end
    total++;
    if (cur_o[0] !== 4'd1 || full_o[0] !== 1'b0) begin
      bad++; $display("FAIL wrap_state cursor=%0d full=%b exp 1/0", cur_o[0], full_o[0]);
    end
    for (int a = 0; a < L; a++) begin
      rd(a, 1'b1);
      total++;
      if (rdat[1] !== 8'h42 + 8'(a)) begin bad++; $display("FAIL scroll_cell addr=%0d got=%h exp=%h", a, rdat[1], 8'h42 + 8'(a)); end
      total++;
      if (rdat[0] !== ((a == 0) ? 8'h51 : 8'h41 + 8'(a))) begin
        bad++; $display("FAIL wrap_cell addr=%0d got=%h exp=%h", a, rdat[0], (a == 0) ? 8'h51 : 8'h41 + 8'(a));
      end
    end
  endtask

  task automatic test_backspace();
    send(8'h08);
    rd(15, 1'b1);
    total++;
    if (cur_o[1] !== 4'd15 || full_o[1] !== 1'b0 || rdat[1] !== 8'h20) begin
      bad++; $display("FAIL bs_full cursor=%0d full=%b cell15=%h exp 15/0/20", cur_o[1], full_o[1], rdat[1]);
    end
    send(8'h08);
    rd(14, 1'b1);
    total++;
    if (cur_o[1] !== 4'd14 || rdat[1] !== 8'h20) begin
      bad++; $display("FAIL bs_step cursor=%0d cell14=%h exp 14/20", cur_o[1], rdat[1]);
    end
    send(8'h0D);
    send(8'h08);
    for (int a = 0; a < L; a++) begin
      rd(a, 1'b1);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdat[m] !== m_rd[m]) begin bad++; $display("FAIL bs_zero_cell dut%0d addr=%0d got=%h exp=%h", m, a, rdat[m], m_rd[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (cur_o[m] !== 4'd0 || full_o[m] !== 1'b0) begin
        bad++; $display("FAIL bs_zero_state dut%0d cursor=%0d full=%b exp 0/0", m, cur_o[m], full_o[m]);
      end
    end
  endtask

  task automatic test_clear();
    int lows;
    send(8'h41);
    send(8'h42);
    valid = 1'b1; data = 8'h0C;
    tick();
    data = 8'h58;
    lows = 0;
    while (rdy[1] === 1'b0 && lows < 40) begin
      lows++;
      total++;
      if (rdy[0] !== rdy[1]) begin bad++; $display("FAIL clear_ready_pair wrap=%b scroll=%b", rdy[0], rdy[1]); end
      tick();
    end
    valid = 1'b0;
    total++;
    if (lows != L) begin bad++; $display("FAIL clear_ready_low cycles=%0d exp=%0d", lows, L); end
    for (int a = 0; a < L; a++) begin
      rd(a, 1'b1);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdat[m] !== 8'h20) begin bad++; $display("FAIL clear_cell dut%0d addr=%0d got=%h exp=20", m, a, rdat[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (cur_o[m] !== 4'd0 || full_o[m] !== 1'b0 || rdy[m] !== 1'b1) begin
        bad++; $display("FAIL clear_state dut%0d cursor=%0d full=%b ready=%b exp 0/0/1", m, cur_o[m], full_o[m], rdy[m]);
      end
    end
  endtask

  task automatic test_caret();
    send(8'h61); send(8'h62); send(8'h63);
    rd(3, 1'b0);
    total++;
    if (rdat[1] !== 8'h5F) begin bad++; $display("FAIL caret_on got=%h exp=5f", rdat[1]); end
    rd(3, 1'b1);
    total++;
    if (rdat[1] !== 8'h20) begin bad++; $display("FAIL caret_off got=%h exp=20", rdat[1]); end
    read_en = 1'b1; addr = 4'd3; strobe = 1'b1; valid = 1'b1; data = 8'h64;
    tick();
    valid = 1'b0; read_en = 1'b0;
    total++;
    if (rdat[1] !== 8'h20) begin bad++; $display("FAIL read_during_write got=%h exp=20", rdat[1]); end
    read_en = 1'b1; addr = 4'd4; strobe = 1'b0; valid = 1'b1; data = 8'h65;
    tick();
    valid = 1'b0; read_en = 1'b0;
    total++;
    if (rdat[1] !== 8'h5F) begin bad++; $display("FAIL caret_prewrite got=%h exp=5f", rdat[1]); end
    addr = 4'd0; strobe = 1'b1;
    tick();
    total++;
    if (rdat[1] !== 8'h5F) begin bad++; $display("FAIL read_hold got=%h exp=5f", rdat[1]); end
    rd(3, 1'b1);
    total++;
    if (rdat[1] !== 8'h64) begin bad++; $display("FAIL caret_written got=%h exp=64", rdat[1]); end
  endtask

  task automatic test_reset_mid_clear();
    send(8'h0C);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (rdy[m] !== 1'b1 || cur_o[m] !== 4'd0) begin
        bad++; $display("FAIL reset_mid_clear dut%0d ready=%b cursor=%0d exp 1/0", m, rdy[m], cur_o[m]);
      end
    end
    for (int a = 0; a < L; a++) begin
      rd(a, 1'b1);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdat[m] !== 8'h20) begin bad++; $display("FAIL reset_mid_clear_cell dut%0d addr=%0d got=%h exp=20", m, a, rdat[m]); end
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 70) data = 8'($urandom_range(32, 126));
      else if (r < 80) data = 8'h08;
      else if (r < 86) data = 8'h0D;
      else if (r < 88) data = 8'h0C;
      else data = 8'($urandom_range(127, 255));
      read_en = $urandom_range(0, 1);
      addr = 4'($urandom_range(0, 15));
      strobe = $urandom_range(0, 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdat[m] !== m_rd[m] || int'(cur_o[m]) != m_cur[m] || full_o[m] !== m_full[m] || rdy[m] !== (m_clr[m] == 0)) begin
          bad++;
          $display("FAIL random n=%0d dut%0d rdata=%h/%h cursor=%0d/%0d full=%b/%b ready=%b/%b (got/exp)",
                   n, m, rdat[m], m_rd[m], cur_o[m], m_cur[m], full_o[m], m_full[m], rdy[m], (m_clr[m] == 0));
        end
      end
    end
    reset = 1'b0; valid = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; data = 8'h00;
    read_en = 1'b0; addr = 4'd0; strobe = 1'b1;
    test_reset();
    test_fill_scroll();
    test_backspace();
    test_clear();
    test_caret();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
